// File: rtl/btn_debounce_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | btn_debounce_pkg : shared state encoding, defaults, button indices   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package btn_debounce_pkg;

  typedef logic [1:0] btn_state_t;

  // Bit 1 of the encoding is the debounced level.
  localparam btn_state_t ST_LOW    = 2'b00;
  localparam btn_state_t ST_ARM_HI = 2'b01;
  localparam btn_state_t ST_HIGH   = 2'b11;
  localparam btn_state_t ST_ARM_LO = 2'b10;

  localparam int NUM_BTN_DEFAULT      = 5;
  localparam int STABLE_CNT_DEFAULT   = 3;
  localparam int REPEAT_DELAY_DEFAULT = 50;
  localparam int REPEAT_RATE_DEFAULT  = 10;

  localparam int BTN_UP    = 0;
  localparam int BTN_DOWN  = 1;
  localparam int BTN_LEFT  = 2;
  localparam int BTN_RIGHT = 3;
  localparam int BTN_START = 4;

  function automatic logic state_level(input btn_state_t st);
    return st[1];
  endfunction

endpackage
`default_nettype wire

// File: rtl/btn_debounce_if.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | btn_debounce_if : raw buttons + tick in, level/pulses out            |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface btn_debounce_if
  import btn_debounce_pkg::*;
#(
  parameter int NUM_BTN = NUM_BTN_DEFAULT
);
  logic               tick_10ms;
  logic [NUM_BTN-1:0] btn_raw;
  logic [NUM_BTN-1:0] btn_level;
  logic [NUM_BTN-1:0] btn_press;
  logic [NUM_BTN-1:0] btn_release;

  modport master (
    output tick_10ms, btn_raw,
    input  btn_level, btn_press, btn_release
  );

  modport slave (
    input  tick_10ms, btn_raw,
    output btn_level, btn_press, btn_release
  );
endinterface
`default_nettype wire

// File: rtl/btn_debounce_chan.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | btn_debounce_chan : synchronizer + debounce FSM for one button       |
// | Optional auto-repeat: BTN_DEBOUNCE_AUTOREPEAT_EN          Rev 1.0    |
// +----------------------------------------------------------------------+
module btn_debounce_chan
  import btn_debounce_pkg::*;
#(
  parameter int STABLE_CNT   = STABLE_CNT_DEFAULT,
  parameter int REPEAT_DELAY = REPEAT_DELAY_DEFAULT,
  parameter int REPEAT_RATE  = REPEAT_RATE_DEFAULT
) (
  input  wire logic mclk,
  input  wire logic clr,
  input  wire logic tick,
  input  wire logic raw,
  output logic      level,
  output logic      press,
  output logic      rel
);
  localparam int                CNT_W    = $clog2(STABLE_CNT + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(STABLE_CNT - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

  if (STABLE_CNT < 2 || REPEAT_RATE < 1 || REPEAT_RATE > REPEAT_DELAY) begin : g_bad_cfg
    $error("btn_debounce_chan: illegal STABLE_CNT/REPEAT_* configuration");
  end

  logic             sync1_q, sync2_q;
  btn_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             accept_press;
  logic             s;

  assign s = sync2_q;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    accept_press = 1'b0;
    release_d    = 1'b0;
    if (tick) begin
      case (state_q)
        ST_LOW: begin
          if (s) begin
            state_d = ST_ARM_HI;
            cnt_d   = CNT_ONE;
          end
        end
        ST_ARM_HI: begin
          if (!s) begin
            state_d = ST_LOW;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d      = ST_HIGH;
            cnt_d        = '0;
            accept_press = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        ST_HIGH: begin
          if (!s) begin
            state_d = ST_ARM_LO;
            cnt_d   = CNT_ONE;
          end
        end
        ST_ARM_LO: begin
          if (s) begin
            state_d = ST_HIGH;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d   = ST_LOW;
            cnt_d     = '0;
            release_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_d = ST_LOW;
          cnt_d   = '0;
        end
      endcase
    end
    level_d = state_level(state_d);
  end

`ifdef BTN_DEBOUNCE_AUTOREPEAT_EN
  localparam int               REP_W      = $clog2(REPEAT_DELAY + 1);
  localparam logic [REP_W-1:0] REP_LAST   = REP_W'(REPEAT_DELAY - 1);
  localparam logic [REP_W-1:0] REP_RELOAD = REP_W'(REPEAT_DELAY - REPEAT_RATE);

  logic [REP_W-1:0] rep_q, rep_d;
  logic             rep_fire;

  // Only counts while settled in HIGH; entry, exit and ARM_LO all clear it.
  always_comb begin
    rep_d    = rep_q;
    rep_fire = 1'b0;
    if (tick) begin
      if (state_q == ST_HIGH && state_d == ST_HIGH) begin
        if (rep_q == REP_LAST) begin
          rep_fire = 1'b1;
          rep_d    = REP_RELOAD;
        end else begin
          rep_d = rep_q + REP_W'(1);
        end
      end else begin
        rep_d = '0;
      end
    end
  end

  always_ff @(posedge mclk) begin
    if (clr) rep_q <= '0;
    else     rep_q <= rep_d;
  end

  assign press_d = accept_press | rep_fire;
`else
  assign press_d = accept_press;
`endif

  always_ff @(posedge mclk) begin
    if (clr) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      state_q   <= ST_LOW;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      sync1_q   <= raw;
      sync2_q   <= sync1_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign level = level_q;
  assign press = press_q;
  assign rel   = release_q;

endmodule
`default_nettype wire

// File: rtl/btn_debounce.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | btn_debounce : NUM_BTN independent debounced button channels         |
// | Optional auto-repeat: BTN_DEBOUNCE_AUTOREPEAT_EN          Rev 1.0    |
// +----------------------------------------------------------------------+
module btn_debounce
  import btn_debounce_pkg::*;
#(
  parameter int NUM_BTN      = NUM_BTN_DEFAULT,
  parameter int STABLE_CNT   = STABLE_CNT_DEFAULT,
  parameter int REPEAT_DELAY = REPEAT_DELAY_DEFAULT,
  parameter int REPEAT_RATE  = REPEAT_RATE_DEFAULT
) (
  input  wire logic       mclk,
  input  wire logic       clr,
  btn_debounce_if.slave   bus
);
  logic [NUM_BTN-1:0] level_vec;
  logic [NUM_BTN-1:0] press_vec;
  logic [NUM_BTN-1:0] release_vec;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_chan
    btn_debounce_chan #(
      .STABLE_CNT   (STABLE_CNT),
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_RATE  (REPEAT_RATE)
    ) u_chan (
      .mclk  (mclk),
      .clr   (clr),
      .tick  (bus.tick_10ms),
      .raw   (bus.btn_raw[i]),
      .level (level_vec[i]),
      .press (press_vec[i]),
      .rel   (release_vec[i])
    );
  end

  assign bus.btn_level   = level_vec;
  assign bus.btn_press   = press_vec;
  assign bus.btn_release = release_vec;

endmodule
`default_nettype wire

// File: tb/tb_btn_debounce.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_btn_debounce : random + directed stimulus, queue scoreboard       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_btn_debounce;
  localparam int NB = 5;
  localparam int SC = 3;
  localparam int RD = 5;
  localparam int RR = 2;
`ifdef BTN_DEBOUNCE_AUTOREPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  typedef struct packed {
    logic [NB-1:0] level;
    logic [NB-1:0] press;
    logic [NB-1:0] rel;
  } obs_t;

  logic mclk = 1'b0;
  logic clr  = 1'b1;

  btn_debounce_if #(.NUM_BTN(NB)) bus ();

  btn_debounce #(
    .NUM_BTN      (NB),
    .STABLE_CNT   (SC),
    .REPEAT_DELAY (RD),
    .REPEAT_RATE  (RR)
  ) dut (
    .mclk (mclk),
    .clr  (clr),
    .bus  (bus)
  );

  always #5 mclk = ~mclk;

  obs_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   done   = 1'b0;

  // Reference: a button's accepted level flips once SC consecutive ticks
  // have sampled the opposite value; hold time counts settled-high ticks.
  bit   r1 [NB];
  bit   r2 [NB];
  bit   lvl[NB];
  int   run [NB];
  int   held[NB];
  bit   m_s;
  obs_t m_e;

  always @(posedge mclk) begin : model
    m_e = '0;
    for (int i = 0; i < NB; i++) begin
      if (clr) begin
        r1[i] = 1'b0; r2[i] = 1'b0; lvl[i] = 1'b0; run[i] = 0; held[i] = 0;
      end else begin
        m_s = r2[i];
        if (bus.tick_10ms) begin
          if (m_s != lvl[i]) begin
            run[i]++;
            held[i] = -1;
            if (run[i] == SC) begin
              lvl[i]  = m_s;
              run[i]  = 0;
              held[i] = 0;
              if (m_s) m_e.press[i] = 1'b1;
              else     m_e.rel[i]   = 1'b1;
            end
          end else begin
            run[i] = 0;
            if (AR && lvl[i]) begin
              held[i]++;
              if (held[i] >= RD && ((held[i] - RD) % RR) == 0) m_e.press[i] = 1'b1;
            end
          end
        end
        r2[i] = r1[i];
        r1[i] = bus.btn_raw[i];
      end
      m_e.level[i] = lvl[i];
    end
    exp_q.push_back(m_e);
  end

  always @(negedge mclk) begin : monitor
    obs_t a, e;
    if (!done) begin
      a = {bus.btn_level, bus.btn_press, bus.btn_release};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_empty t=%0t got level/press/release %b/%b/%b",
                 $time, a.level, a.press, a.rel);
      end else begin
        e = exp_q.pop_front();
        if (a !== e) begin
          errors++;
          $display("FAIL outputs t=%0t got level/press/release %b/%b/%b required %b/%b/%b",
                   $time, a.level, a.press, a.rel, e.level, e.press, e.rel);
        end
      end
    end
  end

  task automatic cyc(input bit t);
    @(posedge mclk);
    #2;
    bus.tick_10ms = t;
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      cyc(1'b1);
      repeat (3) cyc(1'b0);
    end
  endtask

  initial begin
    bus.tick_10ms = 1'b0;
    bus.btn_raw   = '1;
    clr           = 1'b1;
    repeat (3) @(posedge mclk);
    #2;
    clr = 1'b0;
    ticks(5);                       // held through reset: all press together
    bus.btn_raw = '0;
    ticks(5);

    bus.btn_raw[0] = 1'b1; ticks(5); // clean press / release
    bus.btn_raw[0] = 1'b0; ticks(5);

    bus.btn_raw[2] = 1'b1; ticks(1); // bounce
    bus.btn_raw[2] = 1'b0; ticks(1);
    bus.btn_raw[2] = 1'b1; ticks(5);
    bus.btn_raw[2] = 1'b0; ticks(5);

    bus.btn_raw[1] = 1'b1; ticks(5); // release glitch
    bus.btn_raw[1] = 1'b0; ticks(1);
    bus.btn_raw[1] = 1'b1; ticks(8);
    bus.btn_raw[1] = 1'b0; ticks(5);

    bus.btn_raw[3] = 1'b1; ticks(20); // long hold
    bus.btn_raw[3] = 1'b0; ticks(5);

    bus.btn_raw[4] = 1'b1; ticks(2);  // reset mid-acceptance
    clr = 1'b1;
    bus.tick_10ms = 1'b1;
    cyc(1'b1);
    cyc(1'b0);
    clr = 1'b0;
    ticks(5);

    bus.btn_raw = 5'b01010; ticks(5); // tick gating
    for (int k = 0; k < 1000; k++) begin
      bus.btn_raw = NB'($urandom);
      cyc(1'b0);
    end
    ticks(6);

    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(15) == 0) bus.btn_raw[$urandom_range(NB-1)] ^= 1'b1;
      cyc($urandom_range(3) == 0);
    end
    bus.btn_raw = '0;
    ticks(6);

    @(negedge mclk);
    #1;
    done = 1'b1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
